hls_div_scheduler: RTL
======================

# hls_div_scheduler

Shares one HLS-generated 32-bit divider core (ap_ctrl_hs handshake) between NUM_REQ independent requesters. Each requester submits an (a, b) operand pair over a valid/ready channel; the block arbitrates round-robin, sequences ap_start/ap_ready/ap_done on the core, and returns the quotient tagged with the requester index on a single response channel. It sits between the Wishbone register front-ends and the divider instance, replacing direct register-to-core wiring.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- ID_WIDTH, $clog2(NUM_REQ), requester index width
- DATA_WIDTH, 32, operand/result width; must match core

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- s_valid  in  NUM_REQ  per-requester request valid
- s_ready  out  NUM_REQ  per-requester accept
- s_a  in  NUM_REQ*DATA_WIDTH  dividends, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- s_b  in  NUM_REQ*DATA_WIDTH  divisors, same packing
- m_valid  out  1  response valid
- m_ready  in  1  response accept
- m_id  out  ID_WIDTH  requester index of response
- m_c  out  DATA_WIDTH  quotient
- m_err  out  1  divide-by-zero flag
- ap_start  out  1  core start
- ap_ready  in  1  core has consumed inputs
- ap_done  in  1  core result valid (with c_ap_vld)
- ap_idle  in  1  core idle
- core_a, core_b  out  DATA_WIDTH  core operands
- core_c  in  DATA_WIDTH  core result

## Operation
- States: IDLE, START, WAIT, RESP.
- IDLE: if ap_idle and any s_valid, winner g = first set bit of s_valid searching from rr_ptr upward with wrap; s_ready[g]=1 combinationally, all others 0. On that cycle latch s_a/s_b slice g into core_a/core_b, id<=g, rr_ptr<=(g+1) mod NUM_REQ, go START. s_ready is 0 in every other state.
- START: ap_start=1, held until ap_ready sampled 1. If ap_done also 1 that cycle, latch core_c, go RESP; else go WAIT. core_a/core_b stable from latch until RESP exit.
- WAIT: ap_start=0; on ap_done latch core_c into m_c, go RESP.
- RESP: m_valid=1, m_id/m_c/m_err stable; on m_ready go IDLE. m_valid never drops before handshake.
- Only one operation in flight; no request queueing.
- Reset mid-operation (reset drives core too): state IDLE, in-flight result discarded, no response issued.

## Timing
- Reset values: s_ready=0, m_valid=0, m_id=0, m_c=0, m_err=0, ap_start=0, core_a=0, core_b=0, rr_ptr=0.
- Accept at cycle T -> ap_start=1 from T+1.
- ap_done at cycle D -> m_valid=1 at D+1.
- m_ready sampled with m_valid at R -> earliest next accept at R+1 (IDLE).
- Round-robin: with all s_valid held high, grants cycle 0,1,2,3,0...

## Configuration
- HLS_DIV_ZERO_BYPASS_EN defined: in IDLE, if winner's b==0, accept as normal but skip core: go directly to RESP next cycle with m_c = all-ones, m_err=1, ap_start never asserted.
- Undefined: b==0 sent to core like any operand; m_err constant 0.

## Structure
- Package hls_div_pkg: state enum (IDLE/START/WAIT/RESP), DIV_ZERO_RESULT constant (all-ones), default width constants.
- Sub-module hls_rr_arbiter: NUM_REQ request vector + rr_ptr in, one-hot grant + encoded index out, purely combinational.

## Test plan
- Single request i=1, a=100, b=7, core stub latency 5 -> ap_start held until ap_ready, m_valid with m_id=1, m_c=14, m_err=0.
- All four s_valid held, distinct operands -> grant order 0,1,2,3,0; each m_id matches operands' quotient.
- m_ready held low 10 cycles in RESP -> m_valid/m_c stable, no new s_ready until handshake.
- Stub with ap_ready and ap_done in the same cycle (a=9, b=3) -> START goes straight to RESP, m_c=3.
- b=0 with HLS_DIV_ZERO_BYPASS_EN -> no ap_start, m_c=32'hffffffff, m_err=1 one cycle after accept; without macro -> passes to core, m_err=0.
- reset asserted in WAIT -> next cycle all outputs at reset values, no response; subsequent request from requester 2 served normally, rr_ptr restarts at 0.

Source files
------------

// File: rtl/hls_div_pkg.sv
// hls_div_pkg: shared types and constants for the divider scheduler slice.
//   state_e          - scheduler FSM states
//   DIV_ZERO_RESULT  - quotient returned when a zero divisor bypasses the core
//   DefNumReq/DefDataWidth - default requester count and operand width
package hls_div_pkg;

    localparam int unsigned DefNumReq    = 4;
    localparam int unsigned DefDataWidth = 32;

    localparam logic [DefDataWidth-1:0] DIV_ZERO_RESULT = '1;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/hls_rr_arbiter.sv
// hls_rr_arbiter: combinational round-robin pick.
// Ports:
//   req       in  NUM_REQ   request vector
//   ptr       in  ID_WIDTH  index that has highest priority this round
//   grant     out NUM_REQ   one-hot grant (all zero when no request)
//   grant_idx out ID_WIDTH  encoded grant index
//   grant_any out 1         at least one request present
module hls_rr_arbiter
    import hls_div_pkg::*;
#(
    parameter int unsigned NUM_REQ  = DefNumReq,
    parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_idx,
    output logic                grant_any
);

    always_comb begin
        int unsigned j;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        j         = 0;
        // Scan upward from ptr with wrap; first hit wins.
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!grant_any && req[j]) begin
                grant_any = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = ID_WIDTH'(j);
            end
        end
    end

endmodule

// File: rtl/hls_div_scheduler.sv
// hls_div_scheduler: shares one ap_ctrl_hs divider core between NUM_REQ requesters.
// One operation in flight; requesters are served round-robin and the quotient is
// returned on a single response channel tagged with the requester index.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   s_valid/s_ready          per-requester request handshake
//   s_a/s_b                  packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_valid/m_ready          response handshake
//   m_id/m_c/m_err           requester index, quotient, divide-by-zero flag
//   ap_start/ap_ready/ap_done/ap_idle  core control
//   core_a/core_b/core_c     core operands and result
// Build option: HLS_DIV_ZERO_BYPASS_EN - answer zero divisors locally (all-ones,
// m_err=1) without starting the core. Undefined: m_err stays 0.
module hls_div_scheduler
    import hls_div_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DefNumReq,
    parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ),
    parameter int unsigned DATA_WIDTH = DefDataWidth
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            s_valid,
    output logic [NUM_REQ-1:0]            s_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_b,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [ID_WIDTH-1:0]           m_id,
    output logic [DATA_WIDTH-1:0]         m_c,
    output logic                          m_err,
    output logic                          ap_start,
    input  logic                          ap_ready,
    input  logic                          ap_done,
    input  logic                          ap_idle,
    output logic [DATA_WIDTH-1:0]         core_a,
    output logic [DATA_WIDTH-1:0]         core_b,
    input  logic [DATA_WIDTH-1:0]         core_c
);

    state_e                  state;
    logic [ID_WIDTH-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]      grant;
    logic [ID_WIDTH-1:0]     grant_idx;
    logic                    grant_any;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   win_a;
    logic [DATA_WIDTH-1:0]   win_b;
    logic [ID_WIDTH-1:0]     next_ptr;
    logic                    err_q;

    hls_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .req       (s_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        win_a    = s_a[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
        win_b    = s_b[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
        next_ptr = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_WIDTH'(1);
        // Gated by reset so no requester sees an accept while the block is held.
        accept   = (state == StIdle) && ap_idle && grant_any && !reset;
        s_ready  = accept ? grant : '0;
    end

    assign m_err = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StIdle;
            rr_ptr   <= '0;
            m_valid  <= 1'b0;
            m_id     <= '0;
            m_c      <= '0;
            err_q    <= 1'b0;
            ap_start <= 1'b0;
            core_a   <= '0;
            core_b   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        core_a <= win_a;
                        core_b <= win_b;
                        m_id   <= grant_idx;
                        rr_ptr <= next_ptr;
`ifdef HLS_DIV_ZERO_BYPASS_EN
                        if (win_b == '0) begin
                            m_c     <= DATA_WIDTH'(DIV_ZERO_RESULT);
                            err_q   <= 1'b1;
                            m_valid <= 1'b1;
                            state   <= StResp;
                        end else begin
                            ap_start <= 1'b1;
                            state    <= StStart;
                        end
`else
                        ap_start <= 1'b1;
                        state    <= StStart;
`endif
                    end
                end
                StStart: begin
                    if (ap_ready) begin
                        ap_start <= 1'b0;
                        // Core may finish in the same cycle it consumes operands.
                        if (ap_done) begin
                            m_c     <= core_c;
                            err_q   <= 1'b0;
                            m_valid <= 1'b1;
                            state   <= StResp;
                        end else begin
                            state <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (ap_done) begin
                        m_c     <= core_c;
                        err_q   <= 1'b0;
                        m_valid <= 1'b1;
                        state   <= StResp;
                    end
                end
                StResp: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
